// File: rtl/lsu_data_port.sv
// lsu_data_port: data-port load/store unit between the core memory stage and a
// Wishbone-classic data bus. Generates byte-lane selects for 32/64-bit buses,
// replicates store data across lanes, aligns and extends load data, and traps
// misaligned or illegal-size accesses before any bus cycle is issued.
// Optional bus-timeout abort is enabled by defining LSU_TIMEOUT_EN.
module lsu_data_port #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   maddr_i,
  input  logic [DW-1:0]   mdat_i,
  input  logic            mread,
  input  logic            mwrite,
  input  logic [1:0]      msize,
  input  logic            munsigned,
  output logic [DW-1:0]   data_o,
  output logic            mem_stall,
  output logic            mem_bus_err,
  output logic            mem_misaligned,
  input  logic [DW-1:0]   ddat_i,
  input  logic            dack_i,
  input  logic            derr_i,
  output logic [AW-1:0]   daddr_o,
  output logic [DW-1:0]   ddat_o,
  output logic [DW/8-1:0] dsel_o,
  output logic            dcyc_o,
  output logic            dstb_o,
  output logic            dwe_o
);

  localparam int NB = DW / 8;
  localparam int LW = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_ERR} state_t;

  state_t          r_state, w_next;
  logic            w_req, w_legal, w_timeout, w_done;
  logic [LW-1:0]   w_off, r_off;
  logic [NB-1:0]   w_sel, r_sel;
  logic [DW-1:0]   w_wdat, r_wdat;
  logic [AW-1:0]   w_addr, r_addr;
  logic [DW-1:0]   w_shift, w_ldat, r_data;
  logic [1:0]      r_size;
  logic            r_uns, r_we, r_cyc, r_mis, r_berr;
  logic            w_sign;
  int              w_wb;

  assign w_req  = mread | mwrite;
  assign w_off  = maddr_i[LW-1:0];
  assign w_addr = {maddr_i[AW-1:LW], {LW{1'b0}}};
  assign w_done = (r_state == S_RESP) || (r_state == S_ERR);

  // Access legality, lane select and store-data replication for the request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_legal = 1'b1;
    w_sel   = '1;
    w_wdat  = mdat_i;
    case (msize)
      2'b00: begin
        w_sel  = NB'(1'b1) << w_off;
        w_wdat = {NB{mdat_i[7:0]}};
      end
      2'b01: begin
        w_legal = ~w_off[0];
        w_sel   = NB'(2'b11) << w_off;
        w_wdat  = {(DW/16){mdat_i[15:0]}};
      end
      2'b10: begin
        w_legal = (w_off[1:0] == 2'b00);
        w_sel   = NB'(4'hF) << w_off;
        w_wdat  = {(DW/32){mdat_i[31:0]}};
      end
      default: begin
        w_legal = (DW == 64) && (w_off == '0);
      end
    endcase
  end

  // Load alignment: shift the addressed lanes down, then sign/zero-extend.
  always_comb begin
    w_shift = ddat_i >> {r_off, 3'b000};
    w_ldat  = w_shift;
    w_wb    = DW;
    w_sign  = 1'b0;
    case (r_size)
      2'b00:   begin w_wb = 8;  w_sign = w_shift[7];  end
      2'b01:   begin w_wb = 16; w_sign = w_shift[15]; end
      2'b10:   begin w_wb = 32; w_sign = w_shift[31]; end
      default: begin w_wb = DW; w_sign = 1'b0;        end
    endcase
    w_sign = w_sign & ~r_uns;
    for (int i = 0; i < DW; i++) begin
      if (i >= w_wb) w_ldat[i] = w_sign;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;

  // Timeout counter: zero outside BUS so it restarts on every BUS entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_tmo_cnt <= '0;
    else if (r_state != S_BUS) r_tmo_cnt <= '0;
    else                      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_timeout = (r_state == S_BUS) && (r_tmo_cnt == TW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; ack beats error, error beats timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next = w_legal ? S_BUS : S_ERR;
      S_BUS: begin
        if (dack_i)                  w_next = S_RESP;
        else if (derr_i || w_timeout) w_next = S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bus-side and result registers; error flags are single-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc  <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_sel  <= '0;
      r_wdat <= '0;
      r_off  <= '0;
      r_size <= 2'b00;
      r_uns  <= 1'b0;
      r_data <= '0;
      r_mis  <= 1'b0;
      r_berr <= 1'b0;
    end else begin
      r_mis  <= 1'b0;
      r_berr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_legal) begin
              r_cyc  <= 1'b1;
              r_we   <= mwrite;
              r_addr <= w_addr;
              r_sel  <= w_sel;
              r_wdat <= w_wdat;
              r_off  <= w_off;
              r_size <= msize;
              r_uns  <= munsigned;
            end else begin
              r_mis <= 1'b1;
            end
          end
        end
        S_BUS: begin
          if (dack_i) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            // A load flushed mid-cycle still completes on the bus but is not kept.
            if (!r_we && mread) r_data <= w_ldat;
          end else if (derr_i || w_timeout) begin
            r_cyc  <= 1'b0;
            r_we   <= 1'b0;
            r_berr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_stall      = w_req & ~w_done;
  assign mem_bus_err    = r_berr;
  assign mem_misaligned = r_mis;
  assign data_o         = r_data;
  assign daddr_o        = r_addr;
  assign ddat_o         = r_wdat;
  assign dsel_o         = r_sel;
  assign dcyc_o         = r_cyc;
  assign dstb_o         = r_cyc;
  assign dwe_o          = r_we;

endmodule

// File: tb/tb_lsu_data_port.sv
// tb_lsu_data_port: directed bench for lsu_data_port with a 32-bit (suffix _a)
// and a 64-bit (suffix _b) instance. Inputs are driven and outputs sampled on
// the falling edge; the DUT registers on the rising edge. Build with
// LSU_TIMEOUT_EN defined to exercise the timeout abort (TIMEOUT = 8).
module tb_lsu_data_port;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // 32-bit instance
  logic [31:0] maddr_a, mdat_a, data_a, ddat_i_a, daddr_a, ddat_o_a;
  logic        mread_a, mwrite_a, muns_a, stall_a, berr_a, mis_a;
  logic        dack_a, derr_a, dcyc_a, dstb_a, dwe_a;
  logic [1:0]  msize_a;
  logic [3:0]  dsel_a;

  // 64-bit instance
  logic [31:0] maddr_b, daddr_b;
  logic [63:0] mdat_b, data_b, ddat_i_b, ddat_o_b;
  logic        mread_b, mwrite_b, muns_b, stall_b, berr_b, mis_b;
  logic        dack_b, derr_b, dcyc_b, dstb_b, dwe_b;
  logic [1:0]  msize_b;
  logic [7:0]  dsel_b;

  lsu_data_port #(.DW(32), .AW(32), .TIMEOUT(8)) u_dut_a (
    .clk(clk), .rst(rst), .maddr_i(maddr_a), .mdat_i(mdat_a), .mread(mread_a),
    .mwrite(mwrite_a), .msize(msize_a), .munsigned(muns_a), .data_o(data_a),
    .mem_stall(stall_a), .mem_bus_err(berr_a), .mem_misaligned(mis_a),
    .ddat_i(ddat_i_a), .dack_i(dack_a), .derr_i(derr_a), .daddr_o(daddr_a),
    .ddat_o(ddat_o_a), .dsel_o(dsel_a), .dcyc_o(dcyc_a), .dstb_o(dstb_a), .dwe_o(dwe_a)
  );

  lsu_data_port #(.DW(64), .AW(32), .TIMEOUT(8)) u_dut_b (
    .clk(clk), .rst(rst), .maddr_i(maddr_b), .mdat_i(mdat_b), .mread(mread_b),
    .mwrite(mwrite_b), .msize(msize_b), .munsigned(muns_b), .data_o(data_b),
    .mem_stall(stall_b), .mem_bus_err(berr_b), .mem_misaligned(mis_b),
    .ddat_i(ddat_i_b), .dack_i(dack_b), .derr_i(derr_b), .daddr_o(daddr_b),
    .ddat_o(ddat_o_b), .dsel_o(dsel_b), .dcyc_o(dcyc_b), .dstb_o(dstb_b), .dwe_o(dwe_b)
  );

  task automatic test_reset();
    rst = 1'b0;
    maddr_a = '0; mdat_a = '0; mread_a = 0; mwrite_a = 0; msize_a = 0; muns_a = 0;
    ddat_i_a = '0; dack_a = 0; derr_a = 0;
    maddr_b = '0; mdat_b = '0; mread_b = 0; mwrite_b = 0; msize_b = 0; muns_b = 0;
    ddat_i_b = '0; dack_b = 0; derr_b = 0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({dcyc_a, dstb_a, dwe_a, berr_a, mis_a, stall_a} !== 6'b0)
      $display("FAIL rst_ctrl_a: got %b want 000000", {dcyc_a, dstb_a, dwe_a, berr_a, mis_a, stall_a});
    else n_pass++;
    n_total++;
    if ({dsel_a, daddr_a, ddat_o_a, data_a} !== 100'b0)
      $display("FAIL rst_data_a: sel %h addr %h wdat %h data %h want all 0", dsel_a, daddr_a, ddat_o_a, data_a);
    else n_pass++;
    n_total++;
    if ({dcyc_b, dstb_b, dwe_b, berr_b, mis_b, dsel_b, daddr_b, ddat_o_b, data_b} !== 173'b0)
      $display("FAIL rst_b: cyc %b sel %h addr %h wdat %h data %h want all 0", dcyc_b, dsel_b, daddr_b, ddat_o_b, data_b);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_byte();
    maddr_a = 32'h1003; msize_a = 2'b00; muns_a = 0; mread_a = 1;
    #1;
    n_total++;
    if (stall_a !== 1'b1) $display("FAIL lb_stall_req: got %b want 1", stall_a); else n_pass++;
    @(negedge clk);  // BUS
    n_total++;
    if ({dcyc_a, dstb_a, dwe_a} !== 3'b110) $display("FAIL lb_cyc: got %b want 110", {dcyc_a, dstb_a, dwe_a}); else n_pass++;
    n_total++;
    if (dsel_a !== 4'b1000) $display("FAIL lb_sel: got %b want 1000", dsel_a); else n_pass++;
    n_total++;
    if (daddr_a !== 32'h1000) $display("FAIL lb_addr: got %h want 00001000", daddr_a); else n_pass++;
    n_total++;
    if (stall_a !== 1'b1) $display("FAIL lb_stall_bus: got %b want 1", stall_a); else n_pass++;
    ddat_i_a = 32'h80AA55CC; dack_a = 1;
    @(negedge clk);  // RESP
    n_total++;
    if (data_a !== 32'hFFFFFF80) $display("FAIL lb_data: got %h want ffffff80", data_a); else n_pass++;
    n_total++;
    if ({dcyc_a, stall_a} !== 2'b00) $display("FAIL lb_release: cyc/stall %b want 00", {dcyc_a, stall_a}); else n_pass++;
    dack_a = 0; mread_a = 0;
    @(negedge clk);
  endtask

  task automatic test_store_half();
    maddr_a = 32'h2002; msize_a = 2'b01; mdat_a = 32'h0000BEEF; mwrite_a = 1;
    @(negedge clk);  // BUS
    n_total++;
    if (dsel_a !== 4'b1100) $display("FAIL sh_sel: got %b want 1100", dsel_a); else n_pass++;
    n_total++;
    if (ddat_o_a !== 32'hBEEFBEEF) $display("FAIL sh_wdat: got %h want beefbeef", ddat_o_a); else n_pass++;
    n_total++;
    if ({dcyc_a, dwe_a, daddr_a} !== {2'b11, 32'h2000}) $display("FAIL sh_cyc_we_addr: cyc %b we %b addr %h want 1 1 00002000", dcyc_a, dwe_a, daddr_a); else n_pass++;
    dack_a = 1;
    @(negedge clk);  // RESP
    n_total++;
    if ({dcyc_a, stall_a, data_a} !== {2'b00, 32'hFFFFFF80}) $display("FAIL sh_resp: cyc %b stall %b data %h want 0 0 ffffff80", dcyc_a, stall_a, data_a); else n_pass++;
    dack_a = 0; mwrite_a = 0;
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    logic [1:0] sizes [2];
    logic [31:0] addrs [2];
    sizes[0] = 2'b10; addrs[0] = 32'h3001;
    sizes[1] = 2'b11; addrs[1] = 32'h3000;
    for (int k = 0; k < 2; k++) begin
      maddr_a = addrs[k]; msize_a = sizes[k]; mread_a = 1;
      @(negedge clk);  // ERR
      n_total++;
      if ({dcyc_a, mis_a, stall_a, berr_a} !== 4'b0100)
        $display("FAIL mis_err_%0d: cyc/mis/stall/berr %b want 0100", k, {dcyc_a, mis_a, stall_a, berr_a});
      else n_pass++;
      mread_a = 0;
      @(negedge clk);  // IDLE
      n_total++;
      if ({dcyc_a, mis_a} !== 2'b00) $display("FAIL mis_pulse_%0d: cyc/mis %b want 00", k, {dcyc_a, mis_a}); else n_pass++;
    end
  endtask

  task automatic test_dword_64();
    maddr_b = 32'h8; msize_b = 2'b11; muns_b = 0; mread_b = 1;
    @(negedge clk);
    n_total++;
    if ({dcyc_b, dsel_b, daddr_b} !== {1'b1, 8'hFF, 32'h8}) $display("FAIL dw_bus: cyc %b sel %h addr %h want 1 ff 00000008", dcyc_b, dsel_b, daddr_b); else n_pass++;
    ddat_i_b = 64'h0123456789ABCDEF; dack_b = 1;
    @(negedge clk);
    n_total++;
    if (data_b !== 64'h0123456789ABCDEF) $display("FAIL dw_data: got %h want 0123456789abcdef", data_b); else n_pass++;
    dack_b = 0; mread_b = 0;
    @(negedge clk);
    // unsigned word in the upper half
    maddr_b = 32'hC; msize_b = 2'b10; muns_b = 1; mread_b = 1;
    @(negedge clk);
    n_total++;
    if ({dsel_b, daddr_b} !== {8'hF0, 32'h8}) $display("FAIL uw_bus: sel %h addr %h want f0 00000008", dsel_b, daddr_b); else n_pass++;
    dack_b = 1;
    @(negedge clk);
    n_total++;
    if (data_b !== 64'h0000000001234567) $display("FAIL uw_data: got %h want 0000000001234567", data_b); else n_pass++;
    dack_b = 0; mread_b = 0;
    @(negedge clk);
    // signed half at lane offset 2
    maddr_b = 32'hA; msize_b = 2'b01; muns_b = 0; mread_b = 1;
    @(negedge clk);
    n_total++;
    if (dsel_b !== 8'h0C) $display("FAIL sh64_sel: got %h want 0c", dsel_b); else n_pass++;
    dack_b = 1;
    @(negedge clk);
    n_total++;
    if (data_b !== 64'hFFFFFFFFFFFF89AB) $display("FAIL sh64_data: got %h want ffffffffffff89ab", data_b); else n_pass++;
    dack_b = 0; mread_b = 0;
    @(negedge clk);
  endtask

  task automatic test_bus_err();
    maddr_a = 32'h4000; msize_a = 2'b10; muns_a = 0; mread_a = 1;
    repeat (2) @(negedge clk);  // BUS cycles 1 and 2
    @(negedge clk);             // BUS cycle 3
    n_total++;
    if (dcyc_a !== 1'b1) $display("FAIL be_wait: cyc %b want 1", dcyc_a); else n_pass++;
    derr_a = 1; ddat_i_a = 32'h12345678;
    @(negedge clk);  // ERR
    n_total++;
    if ({dcyc_a, dstb_a, berr_a, stall_a} !== 4'b0010) $display("FAIL be_err: cyc/stb/berr/stall %b want 0010", {dcyc_a, dstb_a, berr_a, stall_a}); else n_pass++;
    n_total++;
    if (data_a !== 32'hFFFFFF80) $display("FAIL be_data: got %h want ffffff80", data_a); else n_pass++;
    derr_a = 0; mread_a = 0;
    @(negedge clk);
    n_total++;
    if (berr_a !== 1'b0) $display("FAIL be_pulse: got %b want 0", berr_a); else n_pass++;
  endtask

  task automatic test_back_to_back();
    maddr_a = 32'h1001; msize_a = 2'b00; muns_a = 1; mread_a = 1;
    @(negedge clk);
    ddat_i_a = 32'h80AA55CC; dack_a = 1;
    @(negedge clk);  // RESP
    n_total++;
    if ({stall_a, data_a} !== {1'b0, 32'h00000055}) $display("FAIL bb_first: stall %b data %h want 0 00000055", stall_a, data_a); else n_pass++;
    dack_a = 0; maddr_a = 32'h1004; msize_a = 2'b10; muns_a = 0;
    @(negedge clk);  // IDLE, request still held
    n_total++;
    if ({dcyc_a, stall_a} !== 2'b01) $display("FAIL bb_idle: cyc/stall %b want 01", {dcyc_a, stall_a}); else n_pass++;
    @(negedge clk);  // BUS
    n_total++;
    if ({dcyc_a, dsel_a, daddr_a} !== {1'b1, 4'hF, 32'h1004}) $display("FAIL bb_bus: cyc %b sel %h addr %h want 1 f 00001004", dcyc_a, dsel_a, daddr_a); else n_pass++;
    ddat_i_a = 32'h11223344; dack_a = 1; derr_a = 1;  // ack wins over error
    @(negedge clk);
    n_total++;
    if ({berr_a, stall_a, data_a} !== {2'b00, 32'h11223344}) $display("FAIL bb_ackwin: berr %b stall %b data %h want 0 0 11223344", berr_a, stall_a, data_a); else n_pass++;
    dack_a = 0; derr_a = 0; mread_a = 0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    maddr_a = 32'h6000; msize_a = 2'b10; mread_a = 1;
    @(negedge clk);  // BUS
    mread_a = 0;
    @(negedge clk);
    n_total++;
    if (dcyc_a !== 1'b1) $display("FAIL fl_cyc_held: got %b want 1", dcyc_a); else n_pass++;
    ddat_i_a = 32'hDEADBEEF; dack_a = 1;
    @(negedge clk);
    n_total++;
    if ({dcyc_a, data_a} !== {1'b0, 32'h11223344}) $display("FAIL fl_discard: cyc %b data %h want 0 11223344", dcyc_a, data_a); else n_pass++;
    dack_a = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n_cyc;
    bit seen;
    n_cyc = 0; seen = 0;
    maddr_a = 32'h5000; msize_a = 2'b10; mread_a = 1;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (berr_a) seen = 1;
      else if (dcyc_a) n_cyc++;
    end
    n_total++;
    if (!seen) $display("FAIL to_seen: no bus error within 100 cycles, want pulse");
    else n_pass++;
    n_total++;
    if ({n_cyc, dcyc_a} !== {32'd8, 1'b0}) $display("FAIL to_len: bus cycles %0d cyc %b want 8 0", n_cyc, dcyc_a); else n_pass++;
    mread_a = 0;
    @(negedge clk);
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dcyc_a && !berr_a) n_cyc++;
    end
    n_total++;
    if (n_cyc != 100) $display("FAIL to_wait: cyc high %0d cycles want 100", n_cyc); else n_pass++;
    dack_a = 1;
    @(negedge clk);
    n_total++;
    if ({dcyc_a, stall_a, seen} !== 3'b000) $display("FAIL to_ack: cyc/stall %b want 00", {dcyc_a, stall_a}); else n_pass++;
    dack_a = 0; mread_a = 0;
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_dword_64();
    test_bus_err();
    test_back_to_back();
    test_flush();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_data_port.md
Name: lsu_data_port

Overview:
- Parametrised data-port load/store unit, successor to the single-width data path of the current load/store unit.
- Sits between the core memory stage and a Wishbone-classic data bus.
- Generates true byte-lane selects for 32- or 64-bit buses and aligns/extends load data.
- Detects misaligned accesses before any bus cycle; optional bus-timeout abort.

Parameters:
- DW, 32, data bus width; 32 or 64.
- AW, 32, address width.
- TIMEOUT, 64, cycles to wait for dack_i/derr_i before abort (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- maddr_i  in  AW  access byte address
- mdat_i  in  DW  store data, right-aligned
- mread  in  1  load request, level, held until mem_stall low
- mwrite  in  1  store request, level, held until mem_stall low
- msize  in  2  00 byte, 01 half, 10 word, 11 dword
- munsigned  in  1  zero-extend load
- data_o  out  DW  aligned/extended load result
- mem_stall  out  1  pipeline hold
- mem_bus_err  out  1  one-cycle pulse: derr_i or timeout
- mem_misaligned  out  1  one-cycle pulse: misaligned/illegal size
- ddat_i  in  DW  bus read data
- dack_i  in  1  bus ack
- derr_i  in  1  bus error
- daddr_o  out  AW  bus address, lane bits forced 0
- ddat_o  out  DW  lane-replicated store data
- dsel_o  out  DW/8  byte-lane select
- dcyc_o, dstb_o, dwe_o  out  1 each  Wishbone cycle/strobe/write-enable

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low. Reset values:
  - dcyc_o, dstb_o, dwe_o, mem_bus_err, mem_misaligned: 0
  - dsel_o, daddr_o, ddat_o, data_o: 0
  - State IDLE.
- Lane offset: off = maddr_i[log2(DW/8)-1:0].
- Alignment: half requires off[0]=0; word requires off[1:0]=0; dword requires off=0. msize=11 with DW=32 is illegal.
- mem_stall (combinational) = (mread|mwrite) & ~done, where done is high only in RESP or ERR.
- State IDLE:
  - mread|mwrite with a legal, aligned access: latch address, lanes, data and dwe; assert dcyc_o/dstb_o next edge; go to BUS.
  - Misaligned or illegal: no bus cycle; pulse mem_misaligned; go to ERR.
  - mwrite has priority if both mread and mwrite are high.
- dsel_o:
  - byte: 1<<off
  - half: 3<<off
  - word: 4'hF<<off
  - dword: all ones
- ddat_o: byte replicated DW/8 times, half DW/16 times, word DW/32 times.
- State BUS:
  - dack_i: drop dcyc_o/dstb_o; on a load, register data_o = ddat_i >> (8*off), then sign/zero-extend from the size width (dword: no extension). Go to RESP.
  - derr_i (no dack_i): drop cyc/stb; pulse mem_bus_err; data_o unchanged; go to ERR.
  - dack_i and derr_i in the same cycle: dack_i wins.
- State RESP/ERR: one cycle, done=1 releases the stall; go to IDLE. A new request is accepted only in IDLE, so back-to-back accesses are 3 cycles minimum (IDLE, BUS with ack, RESP).
- Latency: request in IDLE at cycle 0, strobe cycle 1, zero-wait ack cycle 1, stall released cycle 2.
- Request dropped mid-BUS (pipeline flush): the bus cycle still completes; the result is discarded.
- Reset mid-cycle drops cyc/stb immediately.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - Counter cleared on entry to BUS, incremented each BUS cycle.
  - Reaching TIMEOUT-1 without dack_i/derr_i: drop cyc/stb, pulse mem_bus_err, go to ERR.
  - An ack arriving in the same cycle as the timeout wins.
- Undefined: no counter; BUS waits indefinitely.

Test Plan:
- DW=32, load byte maddr_i=0x1003, ddat_i=0x80AA55CC, munsigned=0 -> dsel_o=4'b1000, daddr_o=0x1000, data_o=0xFFFFFF80, stall released 1 cycle after ack.
- DW=32, store half maddr_i=0x2002, mdat_i=0x0000BEEF -> dsel_o=4'b1100, ddat_o=0xBEEFBEEF, dwe_o=1.
- DW=32, load word maddr_i=0x3001 -> no dcyc_o, mem_misaligned one-cycle pulse, mem_stall low next cycle; msize=11 -> same response.
- DW=64, load dword maddr_i=0x8, ddat_i=0x0123456789ABCDEF -> dsel_o=8'hFF, data_o=0x0123456789ABCDEF; unsigned word at 0xC -> data_o=0x0000000001234567.
- derr_i asserted on cycle 3 of BUS -> cyc/stb low next edge, mem_bus_err one pulse, data_o unchanged.
- LSU_TIMEOUT_EN, TIMEOUT=8, no ack -> mem_bus_err pulse after 8 BUS cycles; without the macro, cyc stays high for 100 cycles.
